// File: rtl/fetch_pc_reg_v2.sv
// fetch_pc_reg_v2: Y86-64 fetch predicted-PC register with redirect, bubble, stall watchdog; FETCH_LOAD_CNT_EN adds F_load_cnt
module fetch_pc_reg_v2 #(
   parameter int PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int STALL_CNT_WIDTH = 8,
   parameter int MAX_STALL = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic [PC_WIDTH-1:0] f_predPC,
   input  logic F_stall,
   input  logic F_bubble,
   input  logic redir_valid,
   input  logic [PC_WIDTH-1:0] redir_pc,
   output logic [PC_WIDTH-1:0] F_predPC,
   output logic F_valid,
   output logic [STALL_CNT_WIDTH-1:0] F_stall_cnt,
   output logic F_watchdog,
   output logic F_ctrl_err
`ifdef FETCH_LOAD_CNT_EN
   ,
   output logic [31:0] F_load_cnt
`endif
);
   localparam logic [STALL_CNT_WIDTH-1:0] L_MAX_STALL = STALL_CNT_WIDTH'(MAX_STALL);
   logic [PC_WIDTH-1:0] r_pc;
   logic r_valid;
   logic [STALL_CNT_WIDTH-1:0] r_cnt;
   logic r_err;
   logic w_hold;
   assign w_hold = F_stall & ~redir_valid;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_valid <= 1'b1;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_pc    <= redir_valid ? redir_pc : w_hold ? r_pc : f_predPC;
         r_valid <= redir_valid | (w_hold ? r_valid : ~F_bubble);
         r_cnt   <= w_hold ? ((&r_cnt) ? r_cnt : r_cnt + 1'b1) : '0;
         r_err   <= r_err | (F_stall & F_bubble);
      end
   end
   assign F_predPC    = r_pc;
   assign F_valid     = r_valid;
   assign F_stall_cnt = r_cnt;
   assign F_watchdog  = r_cnt >= L_MAX_STALL;
   assign F_ctrl_err  = r_err;
`ifdef FETCH_LOAD_CNT_EN
   // counts only cycles that deliver a valid PC: redirects and plain loads
   logic [31:0] r_load_cnt;
   logic w_load;
   assign w_load = redir_valid | (~F_stall & ~F_bubble);
   always_ff @(posedge clk) begin
      if (reset) r_load_cnt <= '0;
      else r_load_cnt <= r_load_cnt + 32'(w_load);
   end
   assign F_load_cnt = r_load_cnt;
`endif
endmodule
